// File: rtl/conv_bias_relu_requant.sv
// conv_bias_relu_requant
//
// Post-accumulator stage for the fixed-8 CIFAR-10 conv layers. Each accepted
// beat carries one output-channel sum from the conv MAC array (Q(ACC_W-14).14).
// The stage adds that channel's Q1.7 bias (aligned to the accumulator scale),
// rounds half up back to Q1.7, optionally applies ReLU, saturates to 8 bits and
// counts how often saturation clamped a result.
//
// Two-stage valid/ready pipeline, one beat per cycle:
//   stage 1 : bias add into a register one bit wider than the accumulator
//   stage 2 : round, ReLU, saturate; this register drives the outputs
//
// Build option:
//   BIAS_RELU_EN  defined   -> negative results become 0, output range [0,127],
//                              only positive overflow counts as saturation
//                 undefined -> signed pass-through, clamps at -128 and 127,
//                              both directions count as saturation
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   accumulator beat valid
//   in_ready   out  stage can accept a beat (combinational from out_ready)
//   in_acc     in   signed channel sum, ACC_W bits
//   in_first   in   first channel of a pixel; forces channel index 0
//   bias_row   out  bias ROM row = channel index used by the current beat
//   bias_col   out  bias ROM column, always 0
//   bias_data  in   signed Q1.7 bias, combinational from the ROM
//   out_valid  out  result valid
//   out_ready  in   downstream accepts
//   out_data   out  signed Q1.7 activation
//   out_ch     out  channel index of out_data
//   sat_count  out  saturated results since reset, sticks at 0xFFFF

module conv_bias_relu_requant #(
  parameter int NUM_CH     = 32,
  parameter int ACC_W      = 24,
  parameter int FRAC_SHIFT = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   in_acc,
  input  logic                      in_first,
  output logic [15:0]               bias_row,
  output logic [15:0]               bias_col,
  input  logic signed [7:0]         bias_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [15:0]               sat_count
);

  localparam int CH_W  = $clog2(NUM_CH);
  // One guard bit makes the bias add overflow-free; a second one keeps the
  // rounding constant addition overflow-free as well.
  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;

  localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [RND_W-1:0] MAX_POS  = RND_W'(127);
  localparam logic signed [RND_W-1:0] MIN_NEG  = RND_W'(-128);

  // Channel tracking
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] used_ch;
  logic [CH_W-1:0] next_ch;

  // Pipeline control
  logic in_accept;
  logic s2_load;

  // Stage 1 state and its input datapath
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [CH_W-1:0]         s1_ch;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] bias_ext;
  logic signed [SUM_W-1:0] sum_next;

  // Stage 2 state and its input datapath
  logic                    s2_valid;
  logic signed [RND_W-1:0] rnd_sum;
  logic signed [RND_W-1:0] shifted;
  logic signed [7:0]       sat_data;
  logic                    clamped;

  // The channel index a beat uses: in_first restarts the pixel at channel 0,
  // otherwise the running counter is used. The ROM is addressed with the same
  // index so bias_data lines up with in_acc in the same cycle.
  always_comb begin
    used_ch  = in_first ? '0 : ch;
    next_ch  = (used_ch == LAST_CH) ? '0 : used_ch + 1'b1;
    bias_row = 16'(used_ch);
    bias_col = '0;
  end

  // Stage 2 can take a new value when it is empty or its value is leaving this
  // cycle. Stage 1 moves forward under the same condition, and can refill in
  // that same cycle, so in_ready depends combinationally on out_ready.
  always_comb begin
    s2_load   = !s2_valid || out_ready;
    in_ready  = !s1_valid || s2_load;
    in_accept = in_valid && in_ready;
    out_valid = s2_valid;
  end

  // Bias alignment: Q1.7 times 2^FRAC_SHIFT lands on the accumulator's Q.14
  // scale. Both operands are sign-extended to SUM_W before the add.
  always_comb begin
    acc_ext  = {in_acc[ACC_W-1], in_acc};
    bias_ext = {{(SUM_W - 8 - FRAC_SHIFT){bias_data[7]}}, bias_data,
                {FRAC_SHIFT{1'b0}}};
    sum_next = acc_ext + bias_ext;
  end

  // Round half up (add half an LSB, then arithmetic shift which floors), then
  // clamp into 8 bits. A ReLU zeroing is not counted as a saturation.
  always_comb begin
    rnd_sum  = {s1_sum[SUM_W-1], s1_sum} + RND_HALF;
    shifted  = rnd_sum >>> FRAC_SHIFT;
    sat_data = shifted[7:0];
    clamped  = 1'b0;
`ifdef BIAS_RELU_EN
    if (shifted[RND_W-1]) begin
      sat_data = 8'sh00;
    end else if (shifted > MAX_POS) begin
      sat_data = 8'sh7F;
      clamped  = 1'b1;
    end
`else
    if (shifted > MAX_POS) begin
      sat_data = 8'sh7F;
      clamped  = 1'b1;
    end else if (shifted < MIN_NEG) begin
      sat_data = 8'sh80;
      clamped  = 1'b1;
    end
`endif
  end

  // Channel counter: advances past the index just used, wrapping at the last
  // channel, only when a beat is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (in_accept) begin
      ch <= next_ch;
    end
  end

  // Stage 1 register. When stage 1 may move, its valid bit takes in_valid so
  // an empty slot is propagated as a bubble; data only loads on a real beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_ch    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_next;
        s1_ch  <= used_ch;
      end
    end
  end

  // Stage 2 register and saturation counter. Outputs only change when a new
  // result loads, so they hold while the downstream is stalling. The counter
  // is bumped on the load of a clamped result and sticks at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sat_count <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data;
        out_ch   <= s1_ch;
        if (clamped && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_relu_requant.sv
// tb_conv_bias_relu_requant
//
// Self-checking bench for conv_bias_relu_requant. A monitor on the falling
// edge records every accepted beat into a scoreboard using an arithmetic
// reference model (integer add, floor division, clamp) and checks every
// emitted result, its channel, the saturation count and output stability
// under backpressure. Directed scenarios are followed by a randomized run.
// Honors BIAS_RELU_EN the same way the design does.

module tb_conv_bias_relu_requant;

  localparam int NUM_CH     = 32;
  localparam int ACC_W      = 24;
  localparam int FRAC_SHIFT = 7;
  localparam int CH_W       = $clog2(NUM_CH);

`ifdef BIAS_RELU_EN
  localparam int NEG_EXP = 0;
`else
  localparam int NEG_EXP = -3;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_acc = '0;
  logic                    in_first = 1'b0;
  logic [15:0]             bias_row;
  logic [15:0]             bias_col;
  logic signed [7:0]       bias_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [7:0]       out_data;
  logic [CH_W-1:0]         out_ch;
  logic [15:0]             sat_count;

  logic signed [7:0] bias_rom [NUM_CH];

  typedef struct {
    int data;
    int ch;
    int cumsat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model_ch = 0;
  int   model_sat = 0;
  int   ready_mode = 1;

  // monitor scratch
  exp_t e;
  int   exp_d;
  bit   exp_s;
  int   ech;
  bit   hold_valid = 1'b0;
  int   held_data;
  int   held_ch;

  conv_bias_relu_requant #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .FRAC_SHIFT(FRAC_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_first(in_first),
    .bias_row(bias_row), .bias_col(bias_col), .bias_data(bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  assign bias_data = bias_rom[bias_row[CH_W-1:0]];

  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: value = acc + bias*2^7 on the Q.14 scale, result is
  // floor(value/128 + 1/2), then ReLU (optional) and clamp to 8 bits.
  function automatic void refModel(input int acc, input int bias,
                                   output int data, output bit sat);
    longint v;
    longint r;
    v = longint'(acc) + longint'(bias) * 128 + 64;
    r = v / 128;
    if ((v % 128 != 0) && (v < 0)) r = r - 1;
    sat = 1'b0;
`ifdef BIAS_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) begin
      r = 127;
      sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      sat = 1'b1;
    end
    data = int'(r);
  endfunction

  // out_ready pattern: 0 = stalled, 1 = always ready, 2 = random
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: everything sampled on the falling edge, between driven changes.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_ch   = 0;
      model_sat  = 0;
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, held_data);
        checkOutput("hold_ch", out_ch, held_ch);
      end
      hold_valid = out_valid && !out_ready;
      held_data  = int'(out_data);
      held_ch    = int'(out_ch);

      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_ch", out_ch, e.ch);
          checkOutput("sat_count", sat_count, e.cumsat);
        end
      end

      if (in_valid && in_ready) begin
        ech = in_first ? 0 : model_ch;
        checkOutput("bias_row", bias_row, ech);
        refModel(int'(in_acc), int'(bias_rom[ech]), exp_d, exp_s);
        if (exp_s && model_sat < 65535) model_sat++;
        sb.push_back('{exp_d, ech, model_sat});
        model_ch = (ech == NUM_CH - 1) ? 0 : ech + 1;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted (bounded wait).
  task automatic applyStimulus(input int acc, input bit first);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_acc   = ACC_W'(acc);
    in_first = first;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    if (!got) checkOutput("accept_timeout", 0, 1);
  endtask

  function automatic int smallAcc();
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int acc;

    for (int i = 0; i < NUM_CH; i++) bias_rom[i] = 8'($urandom_range(0, 255));
    bias_rom[0]  = 8'sd32;
    bias_rom[2]  = -8'sd3;
    bias_rom[13] = 8'sd62;

    // reset state
    rst = 1'b1;
    waitCycles(3);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_sat_count", sat_count, 0);
    checkOutput("rst_bias_row", bias_row, 0);
    checkOutput("rst_bias_col", bias_col, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // bias alignment and two-cycle latency
    applyStimulus(0, 1'b1);
    @(negedge clk);
    checkOutput("lat_early", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_data", out_data, 32);
    checkOutput("lat_ch", out_ch, 0);
    @(posedge clk);
    #1;

    // negative result at channel 2
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    waitCycles(4);
    @(negedge clk);
    checkOutput("neg_result", out_data, NEG_EXP);
    checkOutput("neg_ch", out_ch, 2);
    checkOutput("neg_sat", sat_count, 0);
    @(posedge clk);
    #1;

    // rounding and positive saturation at channel 13
    for (int c = 3; c < 13; c++) applyStimulus(0, 1'b0);
    applyStimulus(20000, 1'b0);
    waitCycles(4);
    @(negedge clk);
    checkOutput("round_sat_data", out_data, 127);
    checkOutput("round_sat_ch", out_ch, 13);
    checkOutput("round_sat_cnt", sat_count, 1);
    @(posedge clk);
    #1;

    // -64 rounds to exactly 0
    bias_rom[0] = 8'sd0;
    applyStimulus(-64, 1'b1);
    waitCycles(4);
    @(negedge clk);
    checkOutput("round_zero", out_data, 0);
    checkOutput("round_zero_ch", out_ch, 0);
    @(posedge clk);
    #1;

    // backpressure: 4 beats against a stalled output for 5 cycles
    ready_mode = 0;
    waitCycles(1);
    idx = 0;
    in_valid = 1'b1;
    in_first = 1'b0;
    in_acc   = ACC_W'(smallAcc());
    for (int c = 0; c < 5; c++) begin
      bit took;
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 4) in_acc = ACC_W'(smallAcc());
        else in_valid = 1'b0;
      end
    end
    checkOutput("bp_accepts", idx, 2);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    ready_mode = 1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bit took;
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 4) in_acc = ACC_W'(smallAcc());
      end
    end
    in_valid = 1'b0;
    checkOutput("bp_all_accepted", idx, 4);
    waitCycles(6);
    checkOutput("bp_drained", sb.size(), 0);

    // wrap: 33 beats starting with in_first
    applyStimulus(smallAcc(), 1'b1);
    for (int c = 0; c < 32; c++) applyStimulus(smallAcc(), 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_ch", out_ch, 0);
    @(posedge clk);
    #1;

    // resync: in_first arriving where the counter sits at channel 7
    applyStimulus(smallAcc(), 1'b1);
    for (int c = 1; c < 7; c++) applyStimulus(smallAcc(), 1'b0);
    checkOutput("resync_model_ch", model_ch, 7);
    applyStimulus(smallAcc(), 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("resync_ch", out_ch, 0);
    @(posedge clk);
    #1;

    // randomized run with random backpressure
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) acc = int'($urandom) >>> 8;
      else acc = int'($urandom_range(0, 40000)) - 20000;
      applyStimulus(acc, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) waitCycles(int'($urandom_range(1, 3)));
    end
    ready_mode = 1;
    waitCycles(6);
    checkOutput("rand_drained", sb.size(), 0);
    checkOutput("rand_sat_total", sat_count, model_sat);

    // reset with two beats in flight
    ready_mode = 0;
    waitCycles(1);
    applyStimulus(1000, 1'b0);
    applyStimulus(2000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sat", sat_count, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    ready_mode = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_restart_valid", out_valid, 1);
    checkOutput("midrst_restart_ch", out_ch, 0);
    @(posedge clk);
    #1;
    waitCycles(4);
    checkOutput("final_drained", sb.size(), 0);
    checkOutput("final_sat", sat_count, model_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
